// File: rtl/tomasula_types.sv
// ---------------------------------------------------------------------------
// tomasula_types
//   Shared types for the dispatch stage of the out-of-order core.
//   opclass_t     : class of the op at the instruction-queue head
//   rob_tag_t     : reorder-buffer tag (3 bits, 8 entries)
//   sched_state_t : dispatch scheduler FSM state, exported on state_dbg
// ---------------------------------------------------------------------------
package tomasula_types;

   typedef enum logic [1:0] {
      OPC_ALU  = 2'd0,
      OPC_LDST = 2'd1,
      OPC_NOP  = 2'd2
   } opclass_t;

   typedef logic [2:0] rob_tag_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_FLUSH = 2'd3
   } sched_state_t;

   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

   // Index of the set bit of a one-hot 4-bit vector (0 when no bit is set).
   function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      case (oh)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
//   Combinational 4-way round-robin selector. Grants the first requesting
//   line at or after ptr, wrapping 3 -> 0.
//   req   [3:0] : request lines
//   ptr   [1:0] : highest-priority line this cycle
//   grant [3:0] : one-hot grant, all zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] grant
);

   logic [1:0] idx;
   logic       found;

   always_comb begin
      grant = 4'b0000;
      found = 1'b0;
      idx   = ptr;
      for (int i = 0; i < 4; i++) begin
         // 2-bit addition wraps naturally from 3 back to 0
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dispatch_scheduler.sv
// ---------------------------------------------------------------------------
// dispatch_scheduler
//   Issues at most one op per cycle from the instruction-queue head into the
//   ROB plus an ALU or load/store reservation station.
//
//   Handshake: a dispatch happens in the cycle where iq_valid=1, flush=0,
//   rob_full=0, the scheduler is not in FLUSH and the class resources are
//   free; iq_ack/rob_load (and the station load) pulse combinationally in
//   that same cycle and the queue head is consumed on the rising edge.
//
//   Inputs : clk, reset_n (async, active-low), iq_valid, iq_class,
//            res_empty[3:0], resldst_empty, rob_full, ldst_q_full, flush
//   Outputs: iq_ack, rob_load, res_load[3:0] (one-hot), resldst_load,
//            rob_tag[2:0], stall_cnt[15:0] (saturating), state_dbg (FSM state)
// ---------------------------------------------------------------------------
module dispatch_scheduler
   import tomasula_types::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         iq_valid,
   input  opclass_t     iq_class,
   input  logic [3:0]   res_empty,
   input  logic         resldst_empty,
   input  logic         rob_full,
   input  logic         ldst_q_full,
   input  logic         flush,
   output logic         iq_ack,
   output logic         rob_load,
   output logic [3:0]   res_load,
   output logic         resldst_load,
   output rob_tag_t     rob_tag,
   output logic [15:0]  stall_cnt,
   output sched_state_t state_dbg
);

   sched_state_t state_q, state_d;
   logic [1:0]   rr_ptr_q;
   rob_tag_t     tag_q;
   logic [15:0]  stall_q;

   logic [3:0]   alu_grant;
   logic         class_ok;
   logic         dispatch;
   logic         stall_event;
   logic         clear_ptrs;

   rr_arbiter4 u_rr_arbiter4 (
      .req   (res_empty),
      .ptr   (rr_ptr_q),
      .grant (alu_grant)
   );

   always_comb begin
      class_ok = 1'b0;
      case (iq_class)
         OPC_ALU:  class_ok = |res_empty;
         OPC_LDST: class_ok = resldst_empty & ~ldst_q_full;
         OPC_NOP:  class_ok = 1'b1;
         default:  class_ok = 1'b0;  // undefined encoding never dispatches
      endcase
   end

   // reset_n is folded in so no pulse escapes while reset is held, even
   // though the registers alone would already read IDLE.
   assign dispatch = reset_n & (state_q != ST_FLUSH) & iq_valid & ~flush &
                     ~rob_full & class_ok;

   // The flush request cycle itself is not counted as a stall.
   assign stall_event = iq_valid & ~dispatch & ~flush & (state_q != ST_FLUSH);

   assign clear_ptrs = flush | (state_q == ST_FLUSH);

   always_comb begin
      state_d      = state_q;
      iq_ack       = 1'b0;
      rob_load     = 1'b0;
      res_load     = 4'b0000;
      resldst_load = 1'b0;

      if (dispatch) begin
         iq_ack   = 1'b1;
         rob_load = 1'b1;
         if (iq_class == OPC_ALU)  res_load     = alu_grant;
         if (iq_class == OPC_LDST) resldst_load = 1'b1;
      end

      if (flush)                    state_d = ST_FLUSH;
      else if (state_q == ST_FLUSH) state_d = ST_IDLE;
      else if (dispatch)            state_d = ST_RUN;
      else if (iq_valid)            state_d = ST_STALL;
      else                          state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= 2'd0;
         tag_q    <= 3'd0;
         stall_q  <= 16'd0;
      end else begin
         state_q <= state_d;

         if (clear_ptrs) begin
            rr_ptr_q <= 2'd0;
            tag_q    <= 3'd0;
         end else if (dispatch) begin
            tag_q <= tag_q + 3'd1;
            if (iq_class == OPC_ALU)
               rr_ptr_q <= onehot4_to_idx(alu_grant) + 2'd1;
         end

         if (stall_event && (stall_q != STALL_CNT_MAX))
            stall_q <= stall_q + 16'd1;
      end
   end

   assign rob_tag   = tag_q;
   assign stall_cnt = stall_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dispatch_scheduler
//   Per-cycle scoreboard for dispatch_scheduler. The driver applies one
//   cycle of inputs, evaluates the reference model and pushes the expected
//   output word; the monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_dispatch_scheduler;
   import tomasula_types::*;

   localparam int W = 28;  // {ack, rob_load, res_load[4], ldst_load, tag[3], stall[16], state[2]}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset_n = 1'b0;
   logic         iq_valid = 1'b0;
   opclass_t     iq_class = OPC_NOP;
   logic [3:0]   res_empty = 4'b0000;
   logic         resldst_empty = 1'b0;
   logic         rob_full = 1'b0;
   logic         ldst_q_full = 1'b0;
   logic         flush = 1'b0;
   logic         iq_ack, rob_load, resldst_load;
   logic [3:0]   res_load;
   rob_tag_t     rob_tag;
   logic [15:0]  stall_cnt;
   sched_state_t state_dbg;

   dispatch_scheduler dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .iq_valid      (iq_valid),
      .iq_class      (iq_class),
      .res_empty     (res_empty),
      .resldst_empty (resldst_empty),
      .rob_full      (rob_full),
      .ldst_q_full   (ldst_q_full),
      .flush         (flush),
      .iq_ack        (iq_ack),
      .rob_load      (rob_load),
      .res_load      (res_load),
      .resldst_load  (resldst_load),
      .rob_tag       (rob_tag),
      .stall_cnt     (stall_cnt),
      .state_dbg     (state_dbg)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           failures = 0;

   // ---------------- reference model state ----------------
   sched_state_t m_state = ST_IDLE;
   int           m_rr = 0;
   int           m_tag = 0;
   int           m_stall = 0;

   task automatic model_reset();
      m_state = ST_IDLE;
      m_rr    = 0;
      m_tag   = 0;
      m_stall = 0;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle of stimulus plus its expected outputs.
   task automatic drive_cycle(input logic rst_v, input logic v, input opclass_t c,
                              input logic [3:0] re, input logic rle, input logic rf,
                              input logic lqf, input logic fl, input string nm);
      logic       e_ack, e_rob, e_ldst, disp, avail;
      logic [3:0] e_res;
      int         chosen;
      @(posedge clk);
      #1;
      reset_n = rst_v; iq_valid = v; iq_class = c; res_empty = re;
      resldst_empty = rle; rob_full = rf; ldst_q_full = lqf; flush = fl;

      e_ack = 1'b0; e_rob = 1'b0; e_ldst = 1'b0; e_res = 4'b0000; chosen = -1;
      if (!rst_v) begin
         model_reset();
         exp_q.push_back({1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 16'd0, ST_IDLE});
         name_q.push_back(nm);
         return;
      end

      avail = (c == OPC_ALU) ? (re != 4'b0000) :
              (c == OPC_LDST) ? (rle && !lqf) : 1'b1;
      disp = (m_state != ST_FLUSH) && v && !fl && !rf && avail;
      if (disp) begin
         e_ack = 1'b1;
         e_rob = 1'b1;
         if (c == OPC_ALU) begin
            for (int k = 0; k < 4; k++) begin
               if (chosen < 0 && re[(m_rr + k) % 4]) chosen = (m_rr + k) % 4;
            end
            e_res = 4'b0001 << chosen;
         end
         if (c == OPC_LDST) e_ldst = 1'b1;
      end
      exp_q.push_back({e_ack, e_rob, e_res, e_ldst, 3'(m_tag), 16'(m_stall), m_state});
      name_q.push_back(nm);

      // advance the model to the next cycle
      if (v && !disp && !fl && m_state != ST_FLUSH && m_stall < 65535) m_stall++;
      if (fl || m_state == ST_FLUSH) begin
         m_tag = 0;
         m_rr  = 0;
      end else if (disp) begin
         m_tag = (m_tag + 1) % 8;
         if (c == OPC_ALU) m_rr = (chosen + 1) % 4;
      end
      if (fl)                         m_state = ST_FLUSH;
      else if (m_state == ST_FLUSH)   m_state = ST_IDLE;
      else if (disp)                  m_state = ST_RUN;
      else if (v)                     m_state = ST_STALL;
      else                            m_state = ST_IDLE;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] act, exp;
      string        nm;
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {iq_ack, rob_load, res_load, resldst_load, rob_tag, stall_cnt, state_dbg};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL %s actual ack=%b rob=%b res=%b ldst=%b tag=%0d stall=%0d st=%0d required ack=%b rob=%b res=%b ldst=%b tag=%0d stall=%0d st=%0d at %0t",
                     nm, act[27], act[26], act[25:22], act[21], act[20:18], act[17:2], act[1:0],
                     exp[27], exp[26], exp[25:22], exp[21], exp[20:18], exp[17:2], exp[1:0], $time);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      opclass_t rc;

      // reset held with an eligible head: nothing may pulse
      for (int i = 0; i < 3; i++)
         drive_cycle(1'b0, 1'b1, OPC_ALU, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "reset_hold");

      // first dispatch after reset, then three more ALU ops (grants 0001..1000, tags 0..3)
      for (int i = 0; i < 4; i++)
         drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "alu_b2b");
      // five more dispatches wrap the tag 4..7,0
      for (int i = 0; i < 5; i++)
         drive_cycle(1'b1, 1'b1, (i % 2) ? OPC_NOP : OPC_LDST, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, "tag_wrap");
      // round-robin skipping busy stations
      drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, "rr_skip");
      drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, "rr_skip");
      drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, "alu_none");
      drive_cycle(1'b1, 1'b0, OPC_ALU, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "no_valid");

      // load/store blocked by a full LSQ for three cycles, then released
      drive_cycle(1'b0, 1'b0, OPC_NOP, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, "reset2");
      for (int i = 0; i < 3; i++)
         drive_cycle(1'b1, 1'b1, OPC_LDST, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, "ldst_blocked");
      drive_cycle(1'b1, 1'b1, OPC_LDST, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "ldst_release");
      drive_cycle(1'b1, 1'b0, OPC_NOP, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "after_release");
      check("stall_cnt_after_ldst", 32'(stall_cnt), 32'd3);

      // flush with an eligible head: silent for two cycles, then tag 0 / station 1
      drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "pre_flush");
      drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, "flush_req");
      drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "flush_state");
      drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "post_flush");
      check("post_flush_res_load", 32'(res_load), 32'h1);
      check("post_flush_tag", 32'(rob_tag), 32'd0);

      // reset arriving in the middle of a dispatch cycle kills the pulses at once
      drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "pre_async_rst");
      #6;
      reset_n = 1'b0;
      #1;
      check("async_rst_pulses", 32'({iq_ack, rob_load, res_load, resldst_load}), 32'd0);
      check("async_rst_tag", 32'(rob_tag), 32'd0);
      check("async_rst_stall", 32'(stall_cnt), 32'd0);
      model_reset();
      drive_cycle(1'b0, 1'b1, OPC_ALU, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, "async_rst_hold");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rc = opclass_t'($urandom_range(0, 2));
         drive_cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8), rc,
                     4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 19) == 0), "random");
      end

      // long ROB-full stall saturates the counter
      drive_cycle(1'b0, 1'b0, OPC_NOP, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, "reset3");
      for (int i = 0; i < 65540; i++)
         drive_cycle(1'b1, 1'b1, OPC_ALU, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, "rob_full_sat");
      drive_cycle(1'b1, 1'b0, OPC_NOP, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, "sat_idle");
      #6;
      check("stall_cnt_saturated", 32'(stall_cnt), 32'hFFFF);

      @(posedge clk);
      #6;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
